// File: rtl/exe_unit_pkg.sv
// Shared opcode encodings, widths and FSM state type for the execution unit.
package exe_unit_pkg;

  localparam int unsigned OPER_W = 3;

  localparam logic [OPER_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [OPER_W-1:0] ALU_COMP = 3'd1;
  localparam logic [OPER_W-1:0] ALU_CONV = 3'd2;
  localparam logic [OPER_W-1:0] ALU_SET  = 3'd3;
  localparam logic [OPER_W-1:0] ALU_MUL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } exe_state_e;

endpackage

// File: rtl/exe_unit_pipe_if.sv
// Request/result handshake bundle between a producer, the execution unit and its consumer.
interface exe_unit_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  import exe_unit_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [OPER_W-1:0] i_oper;
  logic [WIDTH-1:0]  i_argA;
  logic [WIDTH-1:0]  i_argB;
  logic              o_valid;
  logic              i_ready;
  logic [WIDTH-1:0]  o_result;
  logic              o_carry;
  logic              o_error;
  logic [3:0]        o_status;

  modport slave (
    input  i_valid, i_oper, i_argA, i_argB, i_ready,
    output o_ready, o_valid, o_result, o_carry, o_error, o_status
  );

  modport master (
    output i_valid, i_oper, i_argA, i_argB, i_ready,
    input  o_ready, o_valid, o_result, o_carry, o_error, o_status
  );

endinterface

// File: rtl/exe_alu_comb.sv
// Single-cycle operations (ADD, signed COMP, CONV to sign-magnitude, SET bit);
// any other opcode, including MUL, yields an error result.
module exe_alu_comb
  import exe_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OPER_W-1:0] oper_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic [WIDTH-1:0]  result_o,
  output logic              carry_o,
  output logic              error_o
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   sum;
  logic [WIDTH-2:0] mag;

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    error_o  = 1'b0;
    sum      = {1'b0, a_i} + {1'b0, b_i};
    // Magnitude of a negative operand: low bits of its two's complement negation
    mag      = ~a_i[WIDTH-2:0] + (WIDTH-1)'(1);
    case (oper_i)
      ALU_ADD: begin
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      ALU_COMP: begin
        if (a_i == b_i)                       result_o = '0;
        else if ($signed(a_i) > $signed(b_i)) result_o = WIDTH'(1);
        else                                  result_o = WIDTH'(2);
      end
      ALU_CONV: begin
        if (a_i == MOST_NEG)   error_o  = 1'b1;
        else if (a_i[WIDTH-1]) result_o = {1'b1, mag};
        else                   result_o = a_i;
      end
      ALU_SET: begin
        if (b_i >= WIDTH'(WIDTH)) begin
          result_o = a_i;
          error_o  = 1'b1;
        end else begin
          result_o = a_i | (WIDTH'(1) << b_i[IDX_W-1:0]);
        end
      end
      default: error_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/exe_unit_pipe.sv
// Execution unit: single-cycle ALU ops plus an optional iterative shift-add
// multiplier, with valid/ready handshakes on both request and result sides.
module exe_unit_pipe
  import exe_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rsn,
  exe_unit_pipe_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  exe_state_e         state_q;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               error_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     psum;

  logic               accept;
  logic               is_mul;
  logic               last_step;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic               alu_error;

  exe_alu_comb #(.WIDTH(WIDTH)) u_alu (
    .oper_i   (bus.i_oper),
    .a_i      (bus.i_argA),
    .b_i      (bus.i_argB),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .error_o  (alu_error)
  );

  assign bus.o_ready = (state_q == IDLE) || ((state_q == DONE) && bus.i_ready);
  assign accept      = bus.i_valid && bus.o_ready;
  assign is_mul      = MUL_EN && (bus.i_oper == ALU_MUL);
  assign last_step   = (cnt_q == CNT_W'(WIDTH - 1));

  // One shift-add step: upper half accumulates the multiplicand when the
  // current multiplier bit (prod_q[0]) is set, then the whole product shifts right.
  always_comb begin
    psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
    prod_d = {psum, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      error_q  <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= MUL;
              valid_q <= 1'b0;
              mcand_q <= bus.i_argA;
              prod_q  <= {{WIDTH{1'b0}}, bus.i_argB};
              cnt_q   <= '0;
            end else begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= alu_result;
              carry_q  <= alu_carry;
              error_q  <= alu_error;
            end
          end else if ((state_q == DONE) && bus.i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_step) begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            result_q <= prod_d[WIDTH-1:0];
            carry_q  <= |prod_d[2*WIDTH-1:WIDTH];
            error_q  <= 1'b0;
            cnt_q    <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_carry  = carry_q;
  assign bus.o_error  = error_q;
  assign bus.o_status = {carry_q, error_q, result_q[WIDTH-1], result_q == '0};

endmodule
